// File: rtl/sdram_arbiter.sv
// SDRAM command-bus arbiter.
// One sequencer (init, auto-refresh, write or read) owns the SDRAM pins at a time.
// Refresh always wins arbitration. Write and read alternate when both are waiting.
// Every pin output is registered and follows the current owner one cycle later.
//
// Handshake: a sequencer raises *_req and holds it until its *_en pulse.
// *_en is high for exactly one cycle, the first cycle of ownership.
// The owner keeps the bus until it pulses its own flag_*_end.
// End flags from any other source are ignored.
module sdram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int BANK_W = 2
) (
  input  logic              sclk,
  input  logic              s_rst,
  input  logic              flag_init_end,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              ref_req,
  input  logic              flag_ref_end,
  input  logic [3:0]        ref_cmd,
  input  logic [ADDR_W-1:0] ref_addr,
  output logic              ref_en,
  input  logic              wr_req,
  input  logic              flag_wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  input  logic              rd_req,
  input  logic              flag_rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BANK_W-1:0] rd_bank,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic [3:0]        sdram_cmd,
  output logic [BANK_W-1:0] sdram_bank,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe
);

  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [4:0] {
    INIT  = 5'b00001,
    ARBIT = 5'b00010,
    AREF  = 5'b00100,
    WRITE = 5'b01000,
    READ  = 5'b10000
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last_wr;
  logic              last_wr_nxt;
  logic              ref_en_nxt;
  logic              wr_en_nxt;
  logic              rd_en_nxt;
  logic [3:0]        cmd_nxt;
  logic [BANK_W-1:0] bank_nxt;
  logic [ADDR_W-1:0] addr_nxt;

  // State register and round-robin memory (last_wr = 1 after a write session).
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      state   <= INIT;
      last_wr <= 1'b0;
    end else begin
      state   <= state_nxt;
      last_wr <= last_wr_nxt;
    end
  end

  // Next-state, grant decision and pin source selection for the current owner.
  always_comb begin
    state_nxt   = state;
    last_wr_nxt = last_wr;
    ref_en_nxt  = 1'b0;
    wr_en_nxt   = 1'b0;
    rd_en_nxt   = 1'b0;
    cmd_nxt     = CMD_NOP;
    bank_nxt    = '0;
    addr_nxt    = '0;
    unique case (state)
      INIT: begin
        cmd_nxt  = init_cmd;
        addr_nxt = init_addr;
        if (flag_init_end) state_nxt = ARBIT;
      end
      ARBIT: begin
        // Grants leave ARBIT only, so the one-cycle enable pulse lines up
        // with the first cycle in the new owner state.
        if (ref_req) begin
          state_nxt  = AREF;
          ref_en_nxt = 1'b1;
        end else if (wr_req && (!rd_req || !last_wr)) begin
          state_nxt = WRITE;
          wr_en_nxt = 1'b1;
        end else if (rd_req) begin
          state_nxt = READ;
          rd_en_nxt = 1'b1;
        end
      end
      AREF: begin
        cmd_nxt  = ref_cmd;
        addr_nxt = ref_addr;
        if (flag_ref_end) state_nxt = ARBIT;
      end
      WRITE: begin
        cmd_nxt  = wr_cmd;
        addr_nxt = wr_addr;
        bank_nxt = wr_bank;
        if (flag_wr_end) begin
          state_nxt   = ARBIT;
          last_wr_nxt = 1'b1;
        end
      end
      READ: begin
        cmd_nxt  = rd_cmd;
        addr_nxt = rd_addr;
        bank_nxt = rd_bank;
        if (flag_rd_end) begin
          state_nxt   = ARBIT;
          last_wr_nxt = 1'b0;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  // Registered grant pulses and pin outputs; DQ data follows the write command.
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      ref_en       <= 1'b0;
      wr_en        <= 1'b0;
      rd_en        <= 1'b0;
      sdram_cmd    <= CMD_NOP;
      sdram_bank   <= '0;
      sdram_addr   <= '0;
      sdram_dq_out <= '0;
      sdram_dq_oe  <= 1'b0;
    end else begin
      ref_en       <= ref_en_nxt;
      wr_en        <= wr_en_nxt;
      rd_en        <= rd_en_nxt;
      sdram_cmd    <= cmd_nxt;
      sdram_bank   <= bank_nxt;
      sdram_addr   <= addr_nxt;
      sdram_dq_out <= wr_data;
      sdram_dq_oe  <= (state == WRITE);
    end
  end

  // Clock enable comes up on the first clock after reset release.
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) sdram_cke <= 1'b0;
    else       sdram_cke <= 1'b1;
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios with literal expectations, then
// randomized sequencer traffic checked every cycle against an ownership model.
module tb_sdram_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int BANK_W = 2;

  // ---------------- clock / reset ----------------
  logic sclk  = 1'b0;
  logic s_rst = 1'b0;
  always #5 sclk = ~sclk;

  logic              flag_init_end = 0;
  logic [3:0]        init_cmd = 4'b0010;
  logic [ADDR_W-1:0] init_addr = 12'h400;
  logic              ref_req = 0, flag_ref_end = 0;
  logic [3:0]        ref_cmd = 4'b0001;
  logic [ADDR_W-1:0] ref_addr = '0;
  logic              wr_req = 0, flag_wr_end = 0;
  logic [3:0]        wr_cmd = 4'b0100;
  logic [ADDR_W-1:0] wr_addr = 12'h005;
  logic [BANK_W-1:0] wr_bank = 2'd1;
  logic [DATA_W-1:0] wr_data = 16'h0007;
  logic              rd_req = 0, flag_rd_end = 0;
  logic [3:0]        rd_cmd = 4'b0101;
  logic [ADDR_W-1:0] rd_addr = 12'h0a0;
  logic [BANK_W-1:0] rd_bank = 2'd2;
  logic              ref_en, wr_en, rd_en;
  logic              sdram_cke, sdram_dq_oe;
  logic [3:0]        sdram_cmd;
  logic [BANK_W-1:0] sdram_bank;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_dq_out;

  sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BANK_W(BANK_W)) dut (
    .sclk(sclk), .s_rst(s_rst), .flag_init_end(flag_init_end),
    .init_cmd(init_cmd), .init_addr(init_addr),
    .ref_req(ref_req), .flag_ref_end(flag_ref_end), .ref_cmd(ref_cmd),
    .ref_addr(ref_addr), .ref_en(ref_en),
    .wr_req(wr_req), .flag_wr_end(flag_wr_end), .wr_cmd(wr_cmd),
    .wr_addr(wr_addr), .wr_bank(wr_bank), .wr_data(wr_data), .wr_en(wr_en),
    .rd_req(rd_req), .flag_rd_end(flag_rd_end), .rd_cmd(rd_cmd),
    .rd_addr(rd_addr), .rd_bank(rd_bank), .rd_en(rd_en),
    .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd), .sdram_bank(sdram_bank),
    .sdram_addr(sdram_addr), .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- ownership model ----------------
  // Owner of the bus: who drives the pins. Idle means arbitration is open.
  localparam int OWN_INIT = 0, OWN_IDLE = 1, OWN_REF = 2, OWN_WR = 3, OWN_RD = 4;
  int owner = OWN_INIT;
  bit wrote_last = 0;
  localparam int VW = 1 + 4 + BANK_W + ADDR_W + DATA_W + 1 + 3;
  logic [VW-1:0] exp_vec = {1'b0, 4'b0111, {BANK_W{1'b0}}, {ADDR_W{1'b0}}, {DATA_W{1'b0}}, 1'b0, 3'b000};

  // Each clock: pins show what the previous owner presented; ownership then moves.
  always @(posedge sclk or posedge s_rst) begin
    logic [3:0] c; logic [BANK_W-1:0] b; logic [ADDR_W-1:0] a;
    int nxt;
    if (s_rst) begin
      owner = OWN_INIT;
      wrote_last = 0;
      exp_vec = {1'b0, 4'b0111, {BANK_W{1'b0}}, {ADDR_W{1'b0}}, {DATA_W{1'b0}}, 1'b0, 3'b000};
    end else begin
      c = 4'b0111; b = '0; a = '0;
      if (owner == OWN_INIT) begin c = init_cmd; a = init_addr; end
      if (owner == OWN_REF)  begin c = ref_cmd;  a = ref_addr;  end
      if (owner == OWN_WR)   begin c = wr_cmd;   a = wr_addr;  b = wr_bank; end
      if (owner == OWN_RD)   begin c = rd_cmd;   a = rd_addr;  b = rd_bank; end
      nxt = owner;
      if (owner == OWN_INIT && flag_init_end) nxt = OWN_IDLE;
      if (owner == OWN_REF && flag_ref_end)   nxt = OWN_IDLE;
      if (owner == OWN_WR && flag_wr_end)     begin nxt = OWN_IDLE; wrote_last = 1; end
      if (owner == OWN_RD && flag_rd_end)     begin nxt = OWN_IDLE; wrote_last = 0; end
      if (owner == OWN_IDLE) begin
        if (ref_req)                   nxt = OWN_REF;
        else if (wr_req && rd_req)     nxt = wrote_last ? OWN_RD : OWN_WR;
        else if (wr_req)               nxt = OWN_WR;
        else if (rd_req)               nxt = OWN_RD;
      end
      exp_vec = {1'b1, c, b, a, wr_data, owner == OWN_WR,
                 owner == OWN_IDLE && nxt == OWN_REF,
                 owner == OWN_IDLE && nxt == OWN_WR,
                 owner == OWN_IDLE && nxt == OWN_RD};
      owner = nxt;
    end
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge sclk) begin
    logic [VW-1:0] act;
    act = {sdram_cke, sdram_cmd, sdram_bank, sdram_addr, sdram_dq_out, sdram_dq_oe,
           ref_en, wr_en, rd_en};
    checks++;
    if (act !== exp_vec) begin
      errors++;
      $display("FAIL model_cycle t=%0t: got %h expected %h", $time, act, exp_vec);
    end
  end

  // ---------------- driver / literal check tasks ----------------
  task automatic step();
    @(negedge sclk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rand_cycle();
    // Requests drop once granted, otherwise they appear at random and are held.
    if (ref_en) ref_req = 0; else if (!ref_req && $urandom_range(0, 7) == 0) ref_req = 1;
    if (wr_en)  wr_req = 0;  else if (!wr_req && $urandom_range(0, 3) == 0) wr_req = 1;
    if (rd_en)  rd_req = 0;  else if (!rd_req && $urandom_range(0, 3) == 0) rd_req = 1;
    flag_init_end = ($urandom_range(0, 3) == 0);
    flag_ref_end  = ($urandom_range(0, 3) == 0);
    flag_wr_end   = ($urandom_range(0, 4) == 0);
    flag_rd_end   = ($urandom_range(0, 4) == 0);
    init_cmd  = 4'($urandom);  init_addr = ADDR_W'($urandom);
    ref_cmd   = 4'($urandom);  ref_addr  = ADDR_W'($urandom);
    wr_cmd    = 4'($urandom);  wr_addr   = ADDR_W'($urandom);
    wr_bank   = BANK_W'($urandom); wr_data = DATA_W'($urandom);
    rd_cmd    = 4'($urandom);  rd_addr   = ADDR_W'($urandom);
    rd_bank   = BANK_W'($urandom);
  endtask

  // ---------------- directed then random stimulus ----------------
  initial begin
    #1 s_rst = 1;
    step();                                                   // N1: in reset
    chk("rst_cmd", 32'(sdram_cmd), 32'h7);
    chk("rst_cke", 32'(sdram_cke), 32'h0);
    chk("rst_en", {29'd0, ref_en, wr_en, rd_en}, 32'h0);
    s_rst = 0;
    step();                                                   // N2
    chk("cke_after_release", 32'(sdram_cke), 32'h1);
    chk("init_pins", {16'(sdram_cmd), 16'(sdram_addr)}, {16'h0002, 16'h0400});
    flag_init_end = 1;
    step();                                                   // N3
    flag_init_end = 0; ref_req = 1;
    step();                                                   // N4: AREF entered
    chk("ref_grant", {29'd0, ref_en, wr_en, rd_en}, 32'h4);
    chk("arbit_nop", 32'(sdram_cmd), 32'h7);
    ref_req = 0;
    step();                                                   // N5
    chk("ref_pulse_one_cycle", 32'(ref_en), 32'h0);
    chk("ref_cmd_pins", 32'(sdram_cmd), 32'h1);
    ref_req = 1; wr_req = 1; rd_req = 1; flag_ref_end = 1;
    step();                                                   // N6
    flag_ref_end = 0;
    step();                                                   // N7: all three -> AREF
    chk("all_req_ref_wins", {29'd0, ref_en, wr_en, rd_en}, 32'h4);
    ref_req = 0; flag_ref_end = 1;
    step();                                                   // N8
    flag_ref_end = 0;
    step();                                                   // N9: WRITE first
    chk("wr_before_rd", {29'd0, ref_en, wr_en, rd_en}, 32'h2);
    wr_req = 0;
    step();                                                   // N10
    chk("wr_pins", {16'(sdram_cmd), 16'(sdram_addr)}, {16'h0004, 16'h0005});
    chk("wr_dq", {15'd0, sdram_dq_oe, sdram_dq_out}, {15'd0, 1'b1, 16'h0007});
    flag_rd_end = 1; flag_ref_end = 1; ref_req = 1;
    step();                                                   // N11
    flag_rd_end = 0; flag_ref_end = 0;
    step();                                                   // N12
    chk("foreign_end_ignored", {28'd0, sdram_cmd}, 32'h4);
    chk("no_preempt", 32'(ref_en), 32'h0);
    flag_wr_end = 1;
    step();                                                   // N13
    flag_wr_end = 0;
    step();                                                   // N14
    chk("gap_nop_and_ref", {27'd0, sdram_cmd, ref_en}, {27'd0, 4'h7, 1'b1});
    chk("nop_dq_oe", 32'(sdram_dq_oe), 32'h0);
    ref_req = 0; flag_ref_end = 1;
    step();                                                   // N15
    flag_ref_end = 0;
    step();                                                   // N16: READ after write
    chk("rd_after_wr", {29'd0, ref_en, wr_en, rd_en}, 32'h1);
    rd_req = 0;
    step();                                                   // N17
    chk("rd_pins", {sdram_cmd, 2'(sdram_bank), sdram_dq_oe, 13'd0, sdram_addr},
        {4'h5, 2'd2, 1'b0, 13'd0, 12'h0a0});
    flag_wr_end = 1;
    step();                                                   // N18
    flag_wr_end = 0; flag_rd_end = 1;
    step();                                                   // N19
    flag_rd_end = 0; wr_req = 1;
    step();                                                   // N20: ARBIT saw wr_req
    chk("wr_grant2", 32'(wr_en), 32'h1);
    wr_req = 0;
    step();                                                   // N21: in WRITE
    chk("wr_active", 32'(sdram_dq_oe), 32'h1);
    #2 s_rst = 1;                                             // reset mid-WRITE
    #1;
    chk("midrst_pins", {26'd0, sdram_cke, sdram_cmd, sdram_dq_oe}, {26'd0, 1'b0, 4'h7, 1'b0});
    chk("midrst_en", {29'd0, ref_en, wr_en, rd_en}, 32'h0);
    step();
    s_rst = 0;
    step();
    chk("midrst_cke_back", 32'(sdram_cke), 32'h1);

    for (int i = 0; i < 3000; i++) begin
      rand_cycle();
      step();
    end
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
